// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: parity modes and FSM state encoding.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_wr, do_rd;

   assign full    = (cnt_q == CNT_FULL);
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign rd_data = mem_q[rptr_q];

   // A write is gated by full alone, so a pop in the same cycle cannot free a slot for it.
   always_comb begin
      do_wr  = wr_en & ~full;
      do_rd  = rd_en & ~empty;
      wptr_d = do_wr ? wptr_q + AW'(1) : wptr_q;
      rptr_d = do_rd ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q;
      case ({do_wr, do_rd})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frames go out back-to-back while words remain queued.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_n,
   input  logic                          i_Tx_DV,
   input  logic [DATA_BITS-1:0]          i_Tx_Byte,
   output logic                          o_Tx_Ready,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Done,
   output logic                          o_Overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

   localparam int            TW     = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);
   localparam logic          ODD    = (PARITY == PAR_ODD);

   state_t               state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shf_q, shf_d;
   logic                 par_q, par_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 done_dly_q, done_dly_d;
   logic                 ovf_q, ovf_d;
   logic                 tick, pop;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 fifo_full, fifo_empty;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_Clock),
      .rst_n   (i_Rst_n),
      .wr_en   (i_Tx_DV),
      .wr_data (i_Tx_Byte),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .count   (o_Fifo_Count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign tick = (tmr_q == T_LAST);

   always_comb begin
      state_d    = state_q;
      tmr_d      = tick ? '0 : tmr_q + TW'(1);
      bit_d      = bit_q;
      shf_d      = shf_q;
      par_d      = par_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmr_d = '0;
            pop   = ~fifo_empty;
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shf_d = shf_q >> 1;
               if (bit_q == D_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == S_LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                  pop     = ~fifo_empty;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Parity is fixed at load time so later FIFO writes cannot disturb the frame in flight.
      if (pop) begin
         state_d = ST_START;
         tmr_d   = '0;
         bit_d   = '0;
         shf_d   = fifo_head;
         par_d   = (^fifo_head) ^ ODD;
      end

      case (state_q)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = shf_q[0];
         ST_PARITY: serial_d = par_q;
         default:   serial_d = 1'b1;
      endcase

      // Line, active and done trail the FSM by one register; done lands right after the frame.
      active_d   = (state_q != ST_IDLE);
      done_dly_d = done_q;
      ovf_d      = i_Tx_DV & fifo_full;
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         bit_q      <= '0;
         shf_q      <= '0;
         par_q      <= 1'b0;
         serial_q   <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         done_dly_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bit_q      <= bit_d;
         shf_q      <= shf_d;
         par_q      <= par_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
         done_dly_q <= done_dly_d;
         ovf_q      <= ovf_d;
      end
   end

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_dly_q;
   assign o_Overflow  = ovf_q;
   assign o_Tx_Ready  = ~fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: five configurations at 4 clocks per bit, line and status recorded every cycle.
module tb_uart_tx_fifo;

   localparam int CPB = 4;
   localparam int NREC = 2048;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] dv    = '0;
   logic [8:0] din   = '0;
   logic [4:0] ser, act, dn, ovf, rdy;
   logic [4:0] cnt0, cnt1, cnt2, cnt4;
   logic [2:0] cnt3;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [4:0] r_ser [NREC];
   logic [4:0] r_act [NREC];
   logic [4:0] r_dn  [NREC];
   logic [4:0] r_ovf [NREC];
   logic [4:0] r_rdy [NREC];
   logic [4:0] r_cnt0[NREC];
   logic [2:0] r_cnt3[NREC];

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB)) u0 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[7:0]),
      .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]),
      .o_Tx_Done(dn[0]), .o_Overflow(ovf[0]), .o_Fifo_Count(cnt0));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) u1 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[6:0]),
      .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]),
      .o_Tx_Done(dn[1]), .o_Overflow(ovf[1]), .o_Fifo_Count(cnt1));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1)) u2 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[6:0]),
      .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]),
      .o_Tx_Done(dn[2]), .o_Overflow(ovf[2]), .o_Fifo_Count(cnt2));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u3 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(din[7:0]),
      .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]),
      .o_Tx_Done(dn[3]), .o_Overflow(ovf[3]), .o_Fifo_Count(cnt3));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u4 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[4]), .i_Tx_Byte(din[7:0]),
      .o_Tx_Ready(rdy[4]), .o_Tx_Active(act[4]), .o_Tx_Serial(ser[4]),
      .o_Tx_Done(dn[4]), .o_Overflow(ovf[4]), .o_Fifo_Count(cnt4));

   // Sample index k holds the outputs just after rising edge k.
   always @(posedge clk) begin
      #1;
      if (cyc < NREC) begin
         r_ser[cyc]  = ser;
         r_act[cyc]  = act;
         r_dn[cyc]   = dn;
         r_ovf[cyc]  = ovf;
         r_rdy[cyc]  = rdy;
         r_cnt0[cyc] = cnt0;
         r_cnt3[cyc] = cnt3;
      end
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int s, input logic [8:0] d);
      @(negedge clk);
      din   = d;
      dv    = '0;
      dv[s] = 1'b1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      dv = '0;
      repeat (n - 1) @(negedge clk);
   endtask

   function automatic int first_low(input int s, input int a);
      for (int i = a; i < a + 200 && i < NREC; i++)
         if (r_ser[i][s] == 1'b0) return i;
      return -1;
   endfunction

   function automatic logic [3:0] bitv(input int s, input int at);
      logic [3:0] v;
      for (int j = 0; j < 4; j++) v[j] = r_ser[at + j][s];
      return v;
   endfunction

   function automatic logic [8:0] dec(input int s, input int st, input int nb);
      logic [8:0] v;
      v = '0;
      for (int i = 0; i < nb; i++) v[i] = r_ser[st + CPB * (1 + i) + 2][s];
      return v;
   endfunction

   function automatic int ones(input int s, input int a, input int b, input int sel);
      int n;
      logic [4:0] v;
      n = 0;
      for (int i = a; i < b; i++) begin
         case (sel)
            0:       v = r_ser[i];
            1:       v = r_act[i];
            2:       v = r_dn[i];
            default: v = r_ovf[i];
         endcase
         n += int'(v[s]);
      end
      return n;
   endfunction

   initial begin
      int base, s0, r, run;
      logic [9:0] line;
      logic [7:0] w [6];

      repeat (3) @(negedge clk);
      chk("rst_ser", ser[0], 1'b1);
      chk("rst_act", act[0], 1'b0);
      chk("rst_done", dn[0], 1'b0);
      chk("rst_ovf", ovf[0], 1'b0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_rdy", rdy, 5'b11111);
      chk("rst_cnt_all", {cnt1, cnt2, cnt3, cnt4}, 0);
      rst_n = 1'b1;
      idle(3);

      // single frame, defaults
      wr(0, 9'h0A5); base = cyc; idle(60);
      s0 = base + 2;
      chk("t1_start_lat", first_low(0, base) - base, 2);
      line = {1'b1, 8'hA5, 1'b0};
      for (int b = 0; b < 10; b++)
         chk($sformatf("t1_bit%0d", b), bitv(0, s0 + CPB * b), {4{line[b]}});
      chk("t1_done_n", ones(0, base, base + 60, 2), 1);
      chk("t1_done_at", r_dn[s0 + 40][0], 1'b1);
      chk("t1_act_n", ones(0, base, base + 60, 1), 40);
      chk("t1_act_first", {r_act[s0 - 1][0], r_act[s0][0]}, 2'b01);

      // 7 data bits with even then odd parity
      wr(1, 9'h055); base = cyc; idle(50);
      s0 = base + 2;
      chk("t2e_data", dec(1, s0, 7), 9'h055);
      chk("t2e_par", bitv(1, s0 + 32), 4'b0000);
      chk("t2e_stop", bitv(1, s0 + 36), 4'b1111);
      chk("t2e_done_at", r_dn[s0 + 40][1], 1'b1);
      chk("t2e_done_n", ones(1, base, base + 50, 2), 1);

      wr(2, 9'h055); base = cyc; idle(50);
      s0 = base + 2;
      chk("t2o_par", bitv(2, s0 + 32), 4'b1111);
      chk("t2o_done_at", r_dn[s0 + 40][2], 1'b1);

      // three words back-to-back
      w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF;
      wr(0, {1'b0, w[0]}); base = cyc;
      wr(0, {1'b0, w[1]}); wr(0, {1'b0, w[2]}); idle(140);
      s0 = base + 2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t3_start%0d", k), bitv(0, s0 + 40 * k), 4'b0000);
         chk($sformatf("t3_data%0d", k), dec(0, s0 + 40 * k, 8), {1'b0, w[k]});
         chk($sformatf("t3_done%0d", k), r_dn[s0 + 40 * (k + 1)][0], 1'b1);
      end
      chk("t3_done_n", ones(0, base, base + 140, 2), 3);
      chk("t3_act_n", ones(0, base, base + 140, 1), 120);
      chk("t3_act_end", r_act[s0 + 120][0], 1'b0);

      // depth-4 FIFO: six writes, last one dropped
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
      wr(3, {1'b0, w[0]}); base = cyc;
      for (int k = 1; k < 6; k++) wr(3, {1'b0, w[k]});
      idle(240);
      s0 = base + 2;
      chk("t4_cnt_pop_wr", r_cnt3[base + 1], 1);
      chk("t4_cnt_full", r_cnt3[base + 4], 4);
      chk("t4_rdy_full", r_rdy[base + 4][3], 1'b0);
      chk("t4_ovf_at", r_ovf[base + 5][3], 1'b1);
      chk("t4_ovf_n", ones(3, base, base + 240, 3), 1);
      chk("t4_done_n", ones(3, base, base + 240, 2), 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("t4_data%0d", k), dec(3, s0 + 40 * k, 8), {1'b0, w[k]});
      chk("t4_cnt_end", r_cnt3[base + 230], 0);

      // two stop bits between back-to-back frames
      wr(4, 9'h000); base = cyc; wr(4, 9'h000); idle(110);
      s0 = base + 2;
      run = 0;
      for (int i = s0 + 36; i < s0 + 60 && r_ser[i][4] == 1'b1; i++) run++;
      chk("t6_stop_run", run, 8);
      chk("t6_start2", bitv(4, s0 + 44), 4'b0000);
      chk("t6_done1", r_dn[s0 + 44][4], 1'b1);
      chk("t6_done2", r_dn[s0 + 88][4], 1'b1);

      // reset mid-DATA with two words queued
      wr(0, 9'h0C3); base = cyc;
      wr(0, 9'h03C); wr(0, 9'h00F); idle(13);
      rst_n = 1'b0; r = cyc;
      @(negedge clk); rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("t5_cnt_before", r_cnt0[r - 1], 2);
      chk("t5_ser_before", r_ser[r - 1][0], 1'b0);
      chk("t5_ser_after", r_ser[r][0], 1'b1);
      chk("t5_act_after", r_act[r][0], 1'b0);
      chk("t5_cnt_after", r_cnt0[r], 0);
      chk("t5_line_high", ones(0, r, r + 100, 0), 100);
      chk("t5_no_done", ones(0, r, r + 100, 2), 0);
      chk("t5_cnt_end", r_cnt0[r + 99], 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
